// File: rtl/dmem_ctrl.sv
// dmem_ctrl: LSU data memory with byte masks, wait states and fault reporting.
// Define DMEM_PARITY_EN to store and check one even-parity bit per byte.
module dmem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_wmask,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0] LOW_MASK =
    ADDR_W'((64'd1 << OFF) - 64'd1);
  localparam logic [ADDR_W-1:0] HI_MASK =
    ~ADDR_W'((64'd1 << (OFF + IW)) - 64'd1);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              accept;
  logic              fault;
  logic              par_bad;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] mem [DEPTH];

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[OFF +: IW];
  assign rd_word   = mem[idx];
  assign fault     = (|(req_addr & LOW_MASK)) ||
                     (|(req_addr & HI_MASK));

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] rd_par;

  assign rd_par = par[idx];

  always_comb begin
    par_bad = 1'b0;
    for (int i = 0; i < NB; i++)
      if ((^rd_word[i*8 +: 8]) != rd_par[i])
        par_bad = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !fault)
      for (int i = 0; i < NB; i++)
        if (req_wmask[i])
          par[idx][i] <= ^req_wdata[i*8 +: 8];
  end
`else
  assign par_bad = 1'b0;
`endif

  // RAM has no reset; a write commits on the accept edge itself
  always_ff @(posedge clk) begin
    if (accept && req_we && !fault)
      for (int i = 0; i < NB; i++)
        if (req_wmask[i])
          mem[idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            cnt       <= '0;
            rsp_err   <= fault || (!req_we && par_bad);
            rsp_rdata <= (fault || req_we) ? '0 : rd_word;
          end
        end
        S_WAIT: begin
          if (cnt == WAIT_LAST) begin
            state <= S_RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (WAIT_STATES 0 and 3) vs a byte-array model.
// Random and directed traffic; parity flip test when DMEM_PARITY_EN is defined.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [3:0]  req_wmask [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_ctrl #(.WAIT_STATES(g * 3)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_wmask (req_wmask[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  int passed = 0;
  int total  = 0;

  // model: bytes of the first 64 words, byte-addressed
  logic [7:0] mb [2][256];

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic bit mfault(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'h1000);
  endfunction

  function automatic logic [31:0] mread(input int d, input logic [31:0] a);
    return {mb[d][a+3], mb[d][a+2], mb[d][a+1], mb[d][a]};
  endfunction

  task automatic mwrite(input int d, input logic [31:0] a,
                        input logic [31:0] w, input logic [3:0] m);
    if (!mfault(a))
      for (int i = 0; i < 4; i++)
        if (m[i]) mb[d][a+i] = w[i*8 +: 8];
  endtask

  task automatic send(input int d, input logic we, input logic [3:0] m,
                      input logic [31:0] a, input logic [31:0] w,
                      output int lat);
    int n;
    req_we[d] = we; req_wmask[d] = m;
    req_addr[d] = a; req_wdata[d] = w;
    req_valid[d] = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      total++; $display("FAIL accept_timeout d%0d", d);
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      total++; $display("FAIL rsp_timeout d%0d", d);
    end
    lat = n + 1;
  endtask

  task automatic complete(input int d);
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
  endtask

  task automatic do_txn(input int d, input logic we, input logic [3:0] m,
                        input logic [31:0] a, input logic [31:0] w,
                        output logic [31:0] rd, output logic er,
                        output int lat);
    send(d, we, m, a, w, lat);
    rd = rsp_rdata[d];
    er = rsp_err[d];
    complete(d);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({req_ready[d], rsp_valid[d], rsp_err[d]} !== 3'b100 ||
          rsp_rdata[d] !== 32'h0) begin
        $display("FAIL reset_state d%0d rdy=%b vld=%b err=%b rd=%h need 1 0 0 0",
                 d, req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]);
      end else passed++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_init(input int d);
    logic [31:0] rd, w;
    logic er;
    int lat;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      do_txn(d, 1'b1, 4'hF, i * 4, w, rd, er, lat);
      mwrite(d, i * 4, w, 4'hF);
      total++;
      if (er !== 1'b0 || rd !== 32'h0)
        $display("FAIL init_write d%0d a=%h err=%b rd=%h need 0 0", d, i*4, er, rd);
      else passed++;
    end
  endtask

  task automatic test_basic(input int d);
    logic [31:0] rd;
    logic er;
    int lat;
    do_txn(d, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, lat);
    mwrite(d, 32'h10, 32'hDEADBEEF, 4'hF);
    total++;
    if (er !== 1'b0 || lat != ws(d) + 1)
      $display("FAIL basic_wr1 d%0d err=%b lat=%0d need 0 %0d", d, er, lat, ws(d)+1);
    else passed++;
    do_txn(d, 1'b1, 4'b0010, 32'h10, 32'h0000AA00, rd, er, lat);
    mwrite(d, 32'h10, 32'h0000AA00, 4'b0010);
    total++;
    if (er !== 1'b0 || lat != ws(d) + 1)
      $display("FAIL basic_wr2 d%0d err=%b lat=%0d need 0 %0d", d, er, lat, ws(d)+1);
    else passed++;
    do_txn(d, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'hDEADAAEF || er !== 1'b0 || lat != ws(d) + 1)
      $display("FAIL basic_rd d%0d rd=%h err=%b lat=%0d need DEADAAEF 0 %0d",
               d, rd, er, lat, ws(d)+1);
    else passed++;
    do_txn(d, 1'b1, 4'hF, 32'h12, 32'h12345678, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0)
      $display("FAIL misalign_wr d%0d err=%b rd=%h need 1 0", d, er, rd);
    else passed++;
    do_txn(d, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, rd, er, lat);
    total++;
    if (er !== 1'b0)
      $display("FAIL zero_mask_wr d%0d err=%b need 0", d, er);
    else passed++;
    do_txn(d, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'hDEADAAEF || er !== 1'b0)
      $display("FAIL unchanged_rd d%0d rd=%h err=%b need DEADAAEF 0", d, rd, er);
    else passed++;
    do_txn(d, 1'b0, 4'h0, 32'h1000, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0)
      $display("FAIL range_rd d%0d err=%b rd=%h need 1 0", d, er, rd);
    else passed++;
  endtask

  task automatic test_hold(input int d);
    logic [31:0] exp1, rd;
    int lat, n;
    exp1 = mread(d, 32'h10);
    send(d, 1'b0, 4'h0, 32'h10, 32'h0, lat);
    req_we[d] = 1'b0; req_addr[d] = 32'h14; req_valid[d] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== exp1 || req_ready[d] !== 1'b0)
        $display("FAIL hold_stable d%0d cyc%0d vld=%b rd=%h rdy=%b need 1 %h 0",
                 d, i, rsp_valid[d], rsp_rdata[d], req_ready[d], exp1);
      else passed++;
    end
    complete(d);
    total++;
    if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0)
      $display("FAIL hold_release d%0d rdy=%b vld=%b need 1 0",
               d, req_ready[d], rsp_valid[d]);
    else passed++;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    rd = rsp_rdata[d];
    total++;
    if (rd !== mread(d, 32'h14) || n != ws(d))
      $display("FAIL hold_second d%0d rd=%h wait=%0d need %h %0d",
               d, rd, n, mread(d, 32'h14), ws(d));
    else passed++;
    complete(d);
  endtask

  task automatic test_random(input int d);
    logic [31:0] a, w, rd, exp;
    logic [3:0] m;
    logic we, er, experr;
    int lat, k;
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      if (k < 6)      a = $urandom_range(0, 63) * 4;
      else if (k < 8) a = $urandom_range(0, 63) * 4 + $urandom_range(1, 3);
      else            a = ($urandom & ~32'h3) | (32'h1 << $urandom_range(12, 31));
      we = 1'($urandom_range(0, 1));
      m  = 4'($urandom_range(0, 15));
      w  = $urandom;
      experr = mfault(a);
      exp = (experr || we) ? 32'h0 : mread(d, a);
      do_txn(d, we, m, a, w, rd, er, lat);
      if (we) mwrite(d, a, w, m);
      total++;
      if (rd !== exp || er !== experr || lat != ws(d) + 1)
        $display("FAIL random d%0d we=%b a=%h rd=%h err=%b lat=%0d need %h %b %0d",
                 d, we, a, rd, er, lat, exp, experr, ws(d)+1);
      else passed++;
    end
  endtask

  task automatic test_reset_midrun();
    int lat;
    send(0, 1'b0, 4'h0, 32'h10, 32'h0, lat);
    reset = 1'b1;
    #2;
    total++;
    if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 ||
        rsp_rdata[0] !== 32'h0 || rsp_err[0] !== 1'b0)
      $display("FAIL midrun_reset rdy=%b vld=%b rd=%h err=%b need 1 0 0 0",
               req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0]);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1)
      $display("FAIL midrun_after vld=%b rdy=%b need 0 1", rsp_valid[0], req_ready[0]);
    else passed++;
  endtask

  task automatic test_reset_wait();
    logic [31:0] w, rd;
    logic er;
    int lat, seen;
    w = $urandom;
    req_we[1] = 1'b1; req_wmask[1] = 4'hF;
    req_addr[1] = 32'h20; req_wdata[1] = w;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    mwrite(1, 32'h20, w, 4'hF);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    total++;
    if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0)
      $display("FAIL wait_reset rdy=%b vld=%b need 1 0", req_ready[1], rsp_valid[1]);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid[1] === 1'b1) seen++;
    end
    total++;
    if (seen != 0)
      $display("FAIL wait_dropped rsp_valid_cycles=%0d need 0", seen);
    else passed++;
    do_txn(1, 1'b0, 4'h0, 32'h20, 32'h0, rd, er, lat);
    total++;
    if (rd !== w || er !== 1'b0)
      $display("FAIL wait_committed rd=%h err=%b need %h 0", rd, er, w);
    else passed++;
  endtask

`ifdef DMEM_PARITY_EN
  task automatic test_parity();
    logic [31:0] w, rd;
    logic er;
    int lat;
    w = $urandom;
    do_txn(1, 1'b1, 4'hF, 32'h20, w, rd, er, lat);
    g_dut[1].u_dut.mem[8][0] = ~g_dut[1].u_dut.mem[8][0];
    do_txn(1, 1'b0, 4'h0, 32'h20, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== (w ^ 32'h1))
      $display("FAIL parity_flip rd=%h err=%b need %h 1", rd, er, w ^ 32'h1);
    else passed++;
  endtask
`endif

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_wmask[d] = 4'h0;
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
    end
    test_reset();
    for (int d = 0; d < 2; d++) begin
      test_init(d);
      test_basic(d);
      test_hold(d);
      test_random(d);
    end
    test_reset_midrun();
    test_reset_wait();
`ifdef DMEM_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
